// File: rtl/basilisk_writeback.sv
// Return-path collector for the basilisk FPU: round-robin merge of per-unit result
// streams onto the float register-file write port, with scoreboard release, sticky fflags and in-flight tracking.
module basilisk_writeback #(
    parameter int NUM_SOURCES     = 4,
    parameter int ADDR_WIDTH      = 5,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_WIDTH     = 5,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_SOURCES-1:0]             src_valid,
    output logic [NUM_SOURCES-1:0]             src_ready,
    input  logic [NUM_SOURCES*ADDR_WIDTH-1:0]  src_dest,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0]  src_data,
    input  logic [NUM_SOURCES*FLAGS_WIDTH-1:0] src_flags,
    input  logic                               issue_valid,
    output logic                               issue_ready,
    output logic                               rf_write_enable,
    output logic [ADDR_WIDTH-1:0]              rf_write_addr,
    output logic [DATA_WIDTH-1:0]              rf_write_data,
    output logic                               sb_clear_valid,
    output logic [ADDR_WIDTH-1:0]              sb_clear_addr,
    output logic [FLAGS_WIDTH-1:0]             fflags,
    input  logic                               fflags_write,
    input  logic [FLAGS_WIDTH-1:0]             fflags_wdata,
    output logic                               idle
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       gnt_idx;
    logic [PTR_W-1:0]       scan_idx;
    logic                   grant;
    logic [ADDR_WIDTH-1:0]  sel_dest;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [FLAGS_WIDTH-1:0] sel_flags;
    logic [FLAGS_WIDTH-1:0] fflags_base;
    logic [CNT_W-1:0]       inflight;
    logic                   issue_fire;

    // Scan starts at the pointer so the most recently served source is checked last.
    always_comb begin
        grant     = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        src_ready = '0;
        sel_dest  = '0;
        sel_data  = '0;
        sel_flags = '0;
        for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
            scan_idx = PTR_W'((32'(rr_ptr) + k) % NUM_SOURCES);
            if (!grant && rst_n && src_valid[scan_idx]) begin
                grant               = 1'b1;
                gnt_idx             = scan_idx;
                src_ready[scan_idx] = 1'b1;
                sel_dest  = src_dest[scan_idx*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data  = src_data[scan_idx*DATA_WIDTH +: DATA_WIDTH];
                sel_flags = src_flags[scan_idx*FLAGS_WIDTH +: FLAGS_WIDTH];
            end
        end
    end

    always_comb begin
        fflags_base = fflags_write ? fflags_wdata : fflags;
        issue_ready = (inflight < CNT_W'(MAX_OUTSTANDING)) || grant;
        issue_fire  = issue_valid && issue_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr          <= '0;
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
            fflags          <= '0;
            inflight        <= '0;
        end else begin
            rf_write_enable <= grant;
            fflags          <= fflags_base | sel_flags;
            if (grant) begin
                rf_write_addr <= sel_dest;
                rf_write_data <= sel_data;
                rr_ptr        <= (gnt_idx == PTR_W'(NUM_SOURCES - 1)) ? '0 : gnt_idx + 1'b1;
            end
            // A retire against an empty count is a protocol error; hold at zero rather than wrap.
            if (issue_fire && !grant)
                inflight <= inflight + 1'b1;
            else if (grant && !issue_fire && inflight != '0)
                inflight <= inflight - 1'b1;
        end
    end

    assign sb_clear_valid = rf_write_enable;
    assign sb_clear_addr  = rf_write_addr;
    assign idle           = (inflight == '0) && !rf_write_enable;

    retire_without_issue : assert property (@(posedge clk) disable iff (!rst_n)
        !(grant && inflight == '0));

endmodule

// File: tb/tb_basilisk_writeback.sv
// Randomized and directed checks of basilisk_writeback against a transaction-level model.
module tb_basilisk_writeback;

    localparam int NS = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int FW = 5;
    localparam int MAXO = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*AW-1:0]  src_dest;
    logic [NS*DW-1:0]  src_data;
    logic [NS*FW-1:0]  src_flags;
    logic              issue_valid = 1'b0;
    logic              issue_ready;
    logic              rf_write_enable;
    logic [AW-1:0]     rf_write_addr;
    logic [DW-1:0]     rf_write_data;
    logic              sb_clear_valid;
    logic [AW-1:0]     sb_clear_addr;
    logic [FW-1:0]     fflags;
    logic              fflags_write = 1'b0;
    logic [FW-1:0]     fflags_wdata = '0;
    logic              idle;

    basilisk_writeback #(.NUM_SOURCES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .FLAGS_WIDTH(FW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst_n(rst_n), .src_valid(src_valid), .src_ready(src_ready),
        .src_dest(src_dest), .src_data(src_data), .src_flags(src_flags),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .sb_clear_valid(sb_clear_valid),
        .sb_clear_addr(sb_clear_addr), .fflags(fflags), .fflags_write(fflags_write),
        .fflags_wdata(fflags_wdata), .idle(idle));

    always #5 clk = ~clk;

    // Per-source stimulus, packed onto the flat buses.
    logic          v   [NS];
    logic [AW-1:0] dst [NS];
    logic [DW-1:0] dat [NS];
    logic [FW-1:0] flg [NS];

    always_comb begin
        src_valid = '0;
        src_dest  = '0;
        src_data  = '0;
        src_flags = '0;
        for (int i = 0; i < NS; i++) begin
            src_valid[i]          = v[i];
            src_dest[i*AW +: AW]  = dst[i];
            src_data[i*DW +: DW]  = dat[i];
            src_flags[i*FW +: FW] = flg[i];
        end
    end

    // Model state: next source to favour, ops in flight, accrued flags, expected write port.
    int            m_ptr;
    int            m_cnt;
    logic [FW-1:0] m_fflags;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [DW-1:0] shadow_rf [32];
    int            obs_g;
    int            n_cmp = 0;
    int            n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_cnt = 0; m_fflags = '0;
        m_we = 1'b0; m_addr = '0; m_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        issue_valid = 1'b0;
        fflags_write = 1'b0;
        for (int i = 0; i < NS; i++) v[i] = 1'b1;
        #1;
        check("rst_src_ready", 64'(src_ready), 64'(0));
        check("rst_rf_we", 64'(rf_write_enable), 64'(0));
        check("rst_sb_valid", 64'(sb_clear_valid), 64'(0));
        check("rst_fflags", 64'(fflags), 64'(0));
        check("rst_idle", 64'(idle), 64'(1));
        @(negedge clk);
        for (int i = 0; i < NS; i++) v[i] = 1'b0;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive at the falling edge, check handshakes, then check registered outputs.
    task automatic step(input logic iss);
        int   g;
        logic exp_ir;
        @(negedge clk);
        issue_valid = iss;
        #1;
        g = -1;
        for (int k = 0; k < NS; k++)
            if (g < 0 && v[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
        exp_ir = (m_cnt < MAXO) || (g >= 0);
        obs_g = -1;
        for (int i = 0; i < NS; i++) if (src_ready[i]) obs_g = i;
        check("src_ready", 64'(src_ready), (g >= 0) ? (64'(1) << g) : 64'(0));
        check("issue_ready", 64'(issue_ready), 64'(exp_ir));
        @(posedge clk);
        #1;
        m_fflags = fflags_write ? fflags_wdata : m_fflags;
        m_we = (g >= 0);
        if (g >= 0) begin
            m_addr = dst[g];
            m_data = dat[g];
            m_fflags = m_fflags | flg[g];
            m_ptr = (g + 1) % NS;
            v[g] = 1'b0;
        end
        if (iss && exp_ir && g < 0) m_cnt++;
        else if (g >= 0 && !(iss && exp_ir) && m_cnt > 0) m_cnt--;
        fflags_write = 1'b0;
        check("rf_we", 64'(rf_write_enable), 64'(m_we));
        check("rf_addr", 64'(rf_write_addr), 64'(m_addr));
        check("rf_data", 64'(rf_write_data), 64'(m_data));
        check("sb_valid", 64'(sb_clear_valid), 64'(m_we));
        check("sb_addr", 64'(sb_clear_addr), 64'(m_addr));
        check("fflags", 64'(fflags), 64'(m_fflags));
        check("idle", 64'(idle), 64'((m_cnt == 0) && !m_we));
        if (rf_write_enable) shadow_rf[rf_write_addr] = rf_write_data;
    endtask

    task automatic load(input int i, input logic [AW-1:0] d, input logic [DW-1:0] x,
                        input logic [FW-1:0] f);
        v[i] = 1'b1; dst[i] = d; dat[i] = x; flg[i] = f;
    endtask

    initial begin
        int pend;
        for (int i = 0; i < NS; i++) begin
            v[i] = 1'b0; dst[i] = '0; dat[i] = '0; flg[i] = '0;
        end
        for (int r = 0; r < 32; r++) shadow_rf[r] = '0;
        model_reset();

        do_reset();
        step(1'b1);
        load(2, 5'd5, 32'h3F800000, 5'b0);
        step(1'b0);
        check("single_grant", 64'(obs_g), 64'(2));
        check("single_addr", 64'(rf_write_addr), 64'(5));
        check("single_data", 64'(rf_write_data), 64'h3F800000);
        step(1'b0);
        check("single_idle", 64'(idle), 64'(1));

        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1);
        for (int i = 0; i < 8; i++) begin
            for (int s = 0; s < NS; s++) load(s, 5'(s), $urandom, 5'b0);
            step(1'b0);
            check("fair_order", 64'(obs_g), 64'(i % NS));
        end

        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1);
        step(1'b0);
        check("throttle_full", 64'(issue_ready), 64'(0));
        load(0, 5'd1, 32'h1, 5'b0);
        step(1'b1);
        step(1'b0);
        check("throttle_still_full", 64'(issue_ready), 64'(0));

        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1);
        load(1, 5'd2, 32'h2, 5'b00001);
        step(1'b0);
        load(3, 5'd3, 32'h3, 5'b10000);
        step(1'b0);
        check("flags_accrue", 64'(fflags), 64'(5'b10001));
        load(0, 5'd4, 32'h4, 5'b00100);
        fflags_write = 1'b1;
        fflags_wdata = 5'b0;
        step(1'b0);
        check("flags_csr_retire", 64'(fflags), 64'(5'b00100));

        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1);
        load(0, 5'd9, 32'h9, 5'b0);
        step(1'b0);
        load(0, 5'd7, 32'hAAAA_0000, 5'b0);
        load(1, 5'd7, 32'hBBBB_0000, 5'b0);
        step(1'b0);
        check("samedest_first", 64'(rf_write_data), 64'hBBBB_0000);
        step(1'b0);
        check("samedest_final", 64'(shadow_rf[7]), 64'hAAAA_0000);

        // Random traffic; a source only presents a result for an op already in flight.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) do_reset();
            pend = 0;
            for (int i = 0; i < NS; i++) if (v[i]) pend++;
            for (int i = 0; i < NS; i++) begin
                if (!v[i] && pend < m_cnt && $urandom_range(0, 2) == 0) begin
                    load(i, 5'($urandom), $urandom, 5'($urandom));
                    pend++;
                end else if (v[i] && $urandom_range(0, 7) == 0) begin
                    dat[i] = $urandom;
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                fflags_write = 1'b1;
                fflags_wdata = 5'($urandom);
            end
            step(1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
